ri5cy_to_ahb: RTL and testbench
===============================

Name: ri5cy_to_ahb

Overview:
- Bridges the RI5CY core data (LSU) port onto an AHB-Lite master interface.
- Sits upstream of the AHB interconnect. Its transfers reach memory-side slaves, including the AHB-to-RI5CY memory bridge.
- Single outstanding transfer, SINGLE bursts only.
- Converts the req/gnt/rvalid protocol into AHB address and data phases, and returns read data and bus errors to the core.

Parameters:
AHB_ADDR_WIDTH, 32, width of haddr_o and data_addr_i
AHB_DATA_WIDTH, 32, width of hwdata_o/hrdata_i and core data buses
HPROT_VAL, 4'b0011, constant driven on hprot_o (data access, privileged)

Ports:
clk  input  1  clock
rstn  input  1  reset, asynchronous, active-low
data_req_i  input  1  core request
data_gnt_o  output  1  request accepted
data_rvalid_o  output  1  response valid (reads and writes)
data_we_i  input  1  1=write
data_be_i  input  4  byte enables
data_addr_i  input  AHB_ADDR_WIDTH  byte address
data_wdata_i  input  AHB_DATA_WIDTH  write data, already lane-aligned
data_rdata_o  output  AHB_DATA_WIDTH  read data
data_err_o  output  1  bus error, valid with data_rvalid_o
haddr_o  output  AHB_ADDR_WIDTH  AHB address
hwrite_o  output  1  AHB write
hsize_o  output  3  AHB size
hburst_o  output  3  always 3'b000 (SINGLE)
hprot_o  output  4  HPROT_VAL
htrans_o  output  2  IDLE=00 / NONSEQ=10 only
hmastlock_o  output  1  always 0
hwdata_o  output  AHB_DATA_WIDTH  AHB write data
hrdata_i  input  AHB_DATA_WIDTH  AHB read data
hready_i  input  1  bus ready
hresp_i  input  1  0=OKAY, 1=ERROR

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; htrans_o=00; data_gnt_o=0; data_rvalid_o=0; data_err_o=0.
  - data_rdata_o=0; haddr_o=0; hwrite_o=0; hsize_o=3'b010; hwdata_o=0.
  - A reset asserted mid-transfer abandons the transfer: no rvalid is issued and htrans_o goes IDLE immediately.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - data_gnt_o = data_req_i (combinational); htrans_o=IDLE.
  - On req, register addr/we/be/wdata and compute haddr/hsize; next state ADDR.
  - hready_i is not required to grant.
- ADDR:
  - htrans_o=NONSEQ; haddr_o/hwrite_o/hsize_o held stable.
  - Stays in ADDR while hready_i=0.
  - On hready_i=1 the address phase completes; next state DATA.
  - data_gnt_o=0.
- DATA:
  - htrans_o=IDLE; hwdata_o = captured wdata, driven for the whole data phase.
  - Waits while hready_i=0, ignoring hresp_i (first cycle of a two-cycle ERROR).
  - On hready_i=1: next state IDLE.
  - In the next cycle, data_rvalid_o=1 for exactly one cycle.
  - data_rdata_o = registered hrdata_i for reads; for writes it holds its previous value.
  - data_err_o = registered hresp_i.
  - data_gnt_o=0.
- Latency: for zero wait states, gnt at cycle 0, NONSEQ at cycle 1, data phase at cycle 2, rvalid at cycle 3.
  - The next gnt is possible in cycle 3, since the FSM is in IDLE and a new req can be granted in the same cycle as rvalid.
- hsize_o / haddr_o[1:0] from be:
  - 1111 -> WORD, 00
  - 0011 -> HALFWORD, 00
  - 1100 -> HALFWORD, 10
  - one-hot 0001/0010/0100/1000 -> BYTE, 00/01/10/11
  - any other pattern, including 0000 -> WORD, 00
  - haddr_o upper bits = data_addr_i upper bits.
- hwdata_o is passed unchanged; hrdata_i is returned unchanged (the core performs lane extraction).
- Error handling:
  - ERROR in DATA still completes normally with rvalid=1, err=1.
  - No retry; the FSM returns to IDLE.
- data_req_i deasserted while in ADDR/DATA is ignored; the transfer completes.

Test Plan:
- Zero-wait read: req addr 0x1000_0004, be 1111, hrdata 0xDEADBEEF -> gnt at c0; NONSEQ, haddr 0x1000_0004, hsize 010 at c1; rvalid=1, rdata 0xDEADBEEF, err=0 at c3.
- Byte write: addr 0x2000_0003, be 1000, wdata 0xAB00_0000 -> haddr 0x2000_0003, hsize 000, hwrite=1; hwdata 0xAB00_0000 in data phase; rvalid at c3.
- Wait states: hready_i=0 for 2 cycles in ADDR and 3 cycles in DATA -> NONSEQ/haddr held stable; hwdata held; rvalid exactly once, 5 cycles later than zero-wait.
- Error: in DATA, drive hresp=1/hready=0 then hresp=1/hready=1 -> rvalid=1, err=1 for one cycle; next req is granted normally with err=0.
- Back-to-back: halfword read be 1100 at 0x40 followed by a word write -> haddr 0x42, hsize 001; second gnt in the rvalid cycle; no overlap of NONSEQ phases.
- Reset in DATA: deassert rstn while waiting -> htrans IDLE, rvalid 0 asynchronously; after release, FSM is IDLE and a new request completes.

Source files
------------

// File: rtl/ri5cy_to_ahb.sv
// RI5CY LSU (req/gnt/rvalid) to AHB-Lite master bridge.
// One outstanding SINGLE transfer. The address, direction, size and write
// data are captured at grant time and held until the next grant. Read data
// and the error flag come back to the core one cycle after the data phase.
module ri5cy_to_ahb #(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned AHB_DATA_WIDTH = 32,
    parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      data_req_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [AHB_ADDR_WIDTH-1:0] data_addr_i,
    input  logic [AHB_DATA_WIDTH-1:0] data_wdata_i,
    output logic [AHB_DATA_WIDTH-1:0] data_rdata_o,
    output logic                      data_err_o,
    output logic [AHB_ADDR_WIDTH-1:0] haddr_o,
    output logic                      hwrite_o,
    output logic [2:0]                hsize_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic [1:0]                htrans_o,
    output logic                      hmastlock_o,
    output logic [AHB_DATA_WIDTH-1:0] hwdata_o,
    input  logic [AHB_DATA_WIDTH-1:0] hrdata_i,
    input  logic                      hready_i,
    input  logic                      hresp_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    state_t                    state_q, state_d;
    logic [AHB_ADDR_WIDTH-1:0] haddr_q;
    logic                      hwrite_q;
    logic [2:0]                hsize_q;
    logic [AHB_DATA_WIDTH-1:0] hwdata_q;
    logic [AHB_DATA_WIDTH-1:0] rdata_q;
    logic                      rvalid_q;
    logic                      err_q;
    logic [2:0]                size_d;
    logic [1:0]                lsb_d;
    logic                      complete;
    logic                      unused_addr_lsb;

    // The byte enables fully determine the low address bits.
    assign unused_addr_lsb = ^data_addr_i[1:0];

    // Data phase finishes when the slave signals ready in DATA.
    assign complete = (state_q == ST_DATA) && hready_i;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state, grant and transfer type.
    always_comb begin
        state_d    = state_q;
        data_gnt_o = 1'b0;
        htrans_o   = HTRANS_IDLE;
        case (state_q)
            ST_IDLE: begin
                data_gnt_o = data_req_i;
                if (data_req_i) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                htrans_o = HTRANS_NONSEQ;
                if (hready_i) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (hready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte enables to transfer size and address lane.
    always_comb begin
        size_d = HSIZE_WORD;
        lsb_d  = 2'b00;
        case (data_be_i)
            4'b1111: begin size_d = HSIZE_WORD; lsb_d = 2'b00; end
            4'b0011: begin size_d = HSIZE_HALF; lsb_d = 2'b00; end
            4'b1100: begin size_d = HSIZE_HALF; lsb_d = 2'b10; end
            4'b0001: begin size_d = HSIZE_BYTE; lsb_d = 2'b00; end
            4'b0010: begin size_d = HSIZE_BYTE; lsb_d = 2'b01; end
            4'b0100: begin size_d = HSIZE_BYTE; lsb_d = 2'b10; end
            4'b1000: begin size_d = HSIZE_BYTE; lsb_d = 2'b11; end
            default: begin size_d = HSIZE_WORD; lsb_d = 2'b00; end
        endcase
    end

    // Capture the request attributes at grant; held through both phases.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_WORD;
            hwdata_q <= '0;
        end else if (data_gnt_o) begin
            haddr_q  <= {data_addr_i[AHB_ADDR_WIDTH-1:2], lsb_d};
            hwrite_q <= data_we_i;
            hsize_q  <= size_d;
            hwdata_q <= data_wdata_i;
        end
    end

    // Response to the core: one-cycle rvalid with error; read data kept on writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= complete;
            err_q    <= complete && hresp_i;
            if (complete && !hwrite_q) rdata_q <= hrdata_i;
        end
    end

    assign haddr_o       = haddr_q;
    assign hwrite_o      = hwrite_q;
    assign hsize_o       = hsize_q;
    assign hwdata_o      = hwdata_q;
    assign hburst_o      = 3'b000;
    assign hprot_o       = HPROT_VAL;
    assign hmastlock_o   = 1'b0;
    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_ri5cy_to_ahb.sv
// Directed bench for ri5cy_to_ahb. Inputs change 1ns after the rising edge;
// outputs are sampled on the falling edge.
module tb_ri5cy_to_ahb;

    logic        clk = 1'b0;
    logic        rstn;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic [31:0] haddr_o;
    logic        hwrite_o;
    logic [2:0]  hsize_o;
    logic [2:0]  hburst_o;
    logic [3:0]  hprot_o;
    logic [1:0]  htrans_o;
    logic        hmastlock_o;
    logic [31:0] hwdata_o;
    logic [31:0] hrdata_i;
    logic        hready_i;
    logic        hresp_i;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ri5cy_to_ahb #(
        .AHB_ADDR_WIDTH(32),
        .AHB_DATA_WIDTH(32),
        .HPROT_VAL     (4'b0011)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .data_req_i   (data_req_i),
        .data_gnt_o   (data_gnt_o),
        .data_rvalid_o(data_rvalid_o),
        .data_we_i    (data_we_i),
        .data_be_i    (data_be_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_err_o   (data_err_o),
        .haddr_o      (haddr_o),
        .hwrite_o     (hwrite_o),
        .hsize_o      (hsize_o),
        .hburst_o     (hburst_o),
        .hprot_o      (hprot_o),
        .htrans_o     (htrans_o),
        .hmastlock_o  (hmastlock_o),
        .hwdata_o     (hwdata_o),
        .hrdata_i     (hrdata_i),
        .hready_i     (hready_i),
        .hresp_i      (hresp_i)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstn = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
        data_addr_i = '0; data_wdata_i = '0; hrdata_i = '0; hready_i = 1'b1; hresp_i = 1'b0;
        tick; tick;
        smp;
        n_vec++; if (htrans_o !== 2'b00) begin n_err++; $display("FAIL rst_htrans got=%b exp=00", htrans_o); end
        n_vec++; if (data_gnt_o !== 1'b0) begin n_err++; $display("FAIL rst_gnt got=%b exp=0", data_gnt_o); end
        n_vec++; if (data_rvalid_o !== 1'b0 || data_err_o !== 1'b0) begin n_err++; $display("FAIL rst_rvalid_err got=%b%b exp=00", data_rvalid_o, data_err_o); end
        n_vec++; if (data_rdata_o !== 32'h0) begin n_err++; $display("FAIL rst_rdata got=%h exp=0", data_rdata_o); end
        n_vec++; if (haddr_o !== 32'h0 || hwrite_o !== 1'b0) begin n_err++; $display("FAIL rst_haddr_hwrite got=%h/%b exp=0/0", haddr_o, hwrite_o); end
        n_vec++; if (hsize_o !== 3'b010) begin n_err++; $display("FAIL rst_hsize got=%b exp=010", hsize_o); end
        n_vec++; if (hwdata_o !== 32'h0) begin n_err++; $display("FAIL rst_hwdata got=%h exp=0", hwdata_o); end
        n_vec++; if (hburst_o !== 3'b000 || hprot_o !== 4'b0011 || hmastlock_o !== 1'b0) begin n_err++; $display("FAIL const_outs got=%b/%b/%b exp=000/0011/0", hburst_o, hprot_o, hmastlock_o); end
        tick; rstn = 1'b1;
        tick;
    endtask

    task automatic test_zero_wait_read;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'b1111; data_addr_i = 32'h1000_0004; hready_i = 1'b1;
        smp; // c0
        n_vec++; if (data_gnt_o !== 1'b1 || htrans_o !== 2'b00) begin n_err++; $display("FAIL rd_c0 gnt/htrans got=%b/%b exp=1/00", data_gnt_o, htrans_o); end
        tick; data_req_i = 1'b0; smp; // c1
        n_vec++; if (htrans_o !== 2'b10 || haddr_o !== 32'h1000_0004 || hsize_o !== 3'b010 || hwrite_o !== 1'b0) begin n_err++; $display("FAIL rd_c1 htrans/haddr/hsize/hwrite got=%b/%h/%b/%b exp=10/10000004/010/0", htrans_o, haddr_o, hsize_o, hwrite_o); end
        n_vec++; if (data_gnt_o !== 1'b0) begin n_err++; $display("FAIL rd_c1_gnt got=%b exp=0", data_gnt_o); end
        tick; hrdata_i = 32'hDEAD_BEEF; smp; // c2
        n_vec++; if (htrans_o !== 2'b00 || data_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rd_c2 htrans/rvalid got=%b/%b exp=00/0", htrans_o, data_rvalid_o); end
        tick; hrdata_i = 32'h0; smp; // c3
        n_vec++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hDEAD_BEEF || data_err_o !== 1'b0) begin n_err++; $display("FAIL rd_c3 rvalid/rdata/err got=%b/%h/%b exp=1/deadbeef/0", data_rvalid_o, data_rdata_o, data_err_o); end
        tick; smp;
        n_vec++; if (data_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rd_c4_rvalid got=%b exp=0", data_rvalid_o); end
    endtask

    task automatic test_byte_write;
        tick;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b1000; data_addr_i = 32'h2000_0003; data_wdata_i = 32'hAB00_0000;
        smp; // c0
        n_vec++; if (data_gnt_o !== 1'b1) begin n_err++; $display("FAIL wr_c0_gnt got=%b exp=1", data_gnt_o); end
        tick; data_req_i = 1'b0; data_wdata_i = 32'h0; smp; // c1
        n_vec++; if (htrans_o !== 2'b10 || haddr_o !== 32'h2000_0003 || hsize_o !== 3'b000 || hwrite_o !== 1'b1) begin n_err++; $display("FAIL wr_c1 htrans/haddr/hsize/hwrite got=%b/%h/%b/%b exp=10/20000003/000/1", htrans_o, haddr_o, hsize_o, hwrite_o); end
        tick; hrdata_i = 32'h1357_9BDF; smp; // c2
        n_vec++; if (hwdata_o !== 32'hAB00_0000) begin n_err++; $display("FAIL wr_c2_hwdata got=%h exp=ab000000", hwdata_o); end
        tick; hrdata_i = 32'h0; smp; // c3
        n_vec++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b0) begin n_err++; $display("FAIL wr_c3 rvalid/err got=%b/%b exp=1/0", data_rvalid_o, data_err_o); end
        n_vec++; if (data_rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rdata_hold got=%h exp=deadbeef", data_rdata_o); end
    endtask

    task automatic test_wait_states;
        int rv_count = 0;
        int rv_cycle = -1;
        logic [9:0] rdy = 10'b00_1000_1000; // bit c = hready in cycle c
        tick;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011; data_addr_i = 32'h3000_0010; data_wdata_i = 32'h1234_5678;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin tick; data_req_i = 1'b0; data_wdata_i = 32'h0; end
            hready_i = rdy[c];
            smp;
            if (c == 0) begin
                n_vec++; if (data_gnt_o !== 1'b1) begin n_err++; $display("FAIL ws_gnt_no_hready got=%b exp=1", data_gnt_o); end
            end
            if (c >= 1 && c <= 3) begin
                n_vec++; if (htrans_o !== 2'b10 || haddr_o !== 32'h3000_0010 || hsize_o !== 3'b001) begin n_err++; $display("FAIL ws_addr_c%0d htrans/haddr/hsize got=%b/%h/%b exp=10/30000010/001", c, htrans_o, haddr_o, hsize_o); end
            end
            if (c >= 4 && c <= 7) begin
                n_vec++; if (htrans_o !== 2'b00 || hwdata_o !== 32'h1234_5678) begin n_err++; $display("FAIL ws_data_c%0d htrans/hwdata got=%b/%h exp=00/12345678", c, htrans_o, hwdata_o); end
            end
            if (data_rvalid_o === 1'b1) begin rv_count++; rv_cycle = c; end
        end
        hready_i = 1'b1;
        n_vec++; if (rv_count != 1 || rv_cycle != 8) begin n_err++; $display("FAIL ws_rvalid count/cycle got=%0d/%0d exp=1/8", rv_count, rv_cycle); end
    endtask

    task automatic test_error;
        tick;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'b1111; data_addr_i = 32'h0000_0050; hready_i = 1'b1;
        tick; data_req_i = 1'b0;                          // c1 ADDR
        tick; hresp_i = 1'b1; hready_i = 1'b0; smp;       // c2 DATA, ERROR first cycle
        n_vec++; if (data_rvalid_o !== 1'b0 || data_err_o !== 1'b0) begin n_err++; $display("FAIL err_c2 rvalid/err got=%b/%b exp=0/0", data_rvalid_o, data_err_o); end
        tick; hresp_i = 1'b1; hready_i = 1'b1; hrdata_i = 32'h0BAD_0BAD; // c3
        tick; hresp_i = 1'b0; hrdata_i = 32'h0; smp;      // c4
        n_vec++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1) begin n_err++; $display("FAIL err_c4 rvalid/err got=%b/%b exp=1/1", data_rvalid_o, data_err_o); end
        tick; smp;
        n_vec++; if (data_rvalid_o !== 1'b0 || data_err_o !== 1'b0) begin n_err++; $display("FAIL err_c5 rvalid/err got=%b/%b exp=0/0", data_rvalid_o, data_err_o); end
        tick;
        data_req_i = 1'b1; data_addr_i = 32'h0000_0054; smp;
        n_vec++; if (data_gnt_o !== 1'b1) begin n_err++; $display("FAIL err_next_gnt got=%b exp=1", data_gnt_o); end
        tick; data_req_i = 1'b0;
        tick; hrdata_i = 32'h1111_1111;
        tick; hrdata_i = 32'h0; smp;
        n_vec++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b0 || data_rdata_o !== 32'h1111_1111) begin n_err++; $display("FAIL err_next rvalid/err/rdata got=%b/%b/%h exp=1/0/11111111", data_rvalid_o, data_err_o, data_rdata_o); end
    endtask

    task automatic test_back_to_back;
        tick;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'b1100; data_addr_i = 32'h0000_0040; hready_i = 1'b1;
        tick; smp; // c1, req held high
        n_vec++; if (htrans_o !== 2'b10 || haddr_o !== 32'h0000_0042 || hsize_o !== 3'b001 || data_gnt_o !== 1'b0) begin n_err++; $display("FAIL b2b_c1 htrans/haddr/hsize/gnt got=%b/%h/%b/%b exp=10/00000042/001/0", htrans_o, haddr_o, hsize_o, data_gnt_o); end
        tick; hrdata_i = 32'hCAFE_0000; smp; // c2
        n_vec++; if (htrans_o !== 2'b00 || data_gnt_o !== 1'b0) begin n_err++; $display("FAIL b2b_c2 htrans/gnt got=%b/%b exp=00/0", htrans_o, data_gnt_o); end
        tick; hrdata_i = 32'h0; data_we_i = 1'b1; data_be_i = 4'b1111; data_addr_i = 32'h0000_0080; data_wdata_i = 32'h55AA_55AA; smp; // c3
        n_vec++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hCAFE_0000 || data_gnt_o !== 1'b1 || htrans_o !== 2'b00) begin n_err++; $display("FAIL b2b_c3 rvalid/rdata/gnt/htrans got=%b/%h/%b/%b exp=1/cafe0000/1/00", data_rvalid_o, data_rdata_o, data_gnt_o, htrans_o); end
        tick; data_req_i = 1'b0; smp; // c4
        n_vec++; if (htrans_o !== 2'b10 || haddr_o !== 32'h0000_0080 || hwrite_o !== 1'b1 || hsize_o !== 3'b010) begin n_err++; $display("FAIL b2b_c4 htrans/haddr/hwrite/hsize got=%b/%h/%b/%b exp=10/00000080/1/010", htrans_o, haddr_o, hwrite_o, hsize_o); end
        tick; smp; // c5
        n_vec++; if (hwdata_o !== 32'h55AA_55AA) begin n_err++; $display("FAIL b2b_c5_hwdata got=%h exp=55aa55aa", hwdata_o); end
        tick; smp; // c6
        n_vec++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'hCAFE_0000) begin n_err++; $display("FAIL b2b_c6 rvalid/rdata got=%b/%h exp=1/cafe0000", data_rvalid_o, data_rdata_o); end
    endtask

    task automatic test_reset_midxfer;
        // Reset while stalled in ADDR: NONSEQ must drop without waiting for a clock.
        tick;
        data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'b1111; data_addr_i = 32'h0000_0100; hready_i = 1'b0;
        tick; data_req_i = 1'b0; #2;
        rstn = 1'b0; #1;
        n_vec++; if (htrans_o !== 2'b00 || haddr_o !== 32'h0) begin n_err++; $display("FAIL rstaddr htrans/haddr got=%b/%h exp=00/0", htrans_o, haddr_o); end
        tick; rstn = 1'b1;
        // Reset in DATA with ready pending: no rvalid may follow.
        data_req_i = 1'b1; data_addr_i = 32'h0000_0200; hready_i = 1'b1;
        tick; data_req_i = 1'b0;
        tick; hready_i = 1'b0; #2;                        // DATA, waiting
        rstn = 1'b0; hready_i = 1'b1; #1;
        n_vec++; if (htrans_o !== 2'b00 || data_rvalid_o !== 1'b0 || hsize_o !== 3'b010) begin n_err++; $display("FAIL rstdata htrans/rvalid/hsize got=%b/%b/%b exp=00/0/010", htrans_o, data_rvalid_o, hsize_o); end
        tick; smp;
        n_vec++; if (data_rvalid_o !== 1'b0) begin n_err++; $display("FAIL rstdata_no_rvalid got=%b exp=0", data_rvalid_o); end
        tick; rstn = 1'b1;
        tick;
        data_req_i = 1'b1; data_addr_i = 32'h0000_0300; smp;
        n_vec++; if (data_gnt_o !== 1'b1) begin n_err++; $display("FAIL rst_after_gnt got=%b exp=1", data_gnt_o); end
        tick; data_req_i = 1'b0;
        tick; hrdata_i = 32'h7777_0001;
        tick; hrdata_i = 32'h0; smp;
        n_vec++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h7777_0001) begin n_err++; $display("FAIL rst_after_xfer rvalid/rdata got=%b/%h exp=1/77770001", data_rvalid_o, data_rdata_o); end
    endtask

    initial begin
        test_reset;
        test_zero_wait_read;
        test_byte_write;
        test_wait_states;
        test_error;
        test_back_to_back;
        test_reset_midxfer;
        tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
